// File: rtl/uart_host_fifo_if.sv
// uart_host_fifo_if: host-side and UART-core-side signals of the host FIFO block
interface uart_host_fifo_if #(parameter int AW = 4);
  logic          tx_push;
  logic [7:0]    tx_wdata;
  logic          tx_full;
  logic [AW:0]   tx_count;
  logic          tx_flush;
  logic          rx_pop;
  logic [7:0]    rx_rdata;
  logic [4:0]    rx_rerr;
  logic          rx_empty;
  logic [AW:0]   rx_count;
  logic          rx_flush;
  logic          rx_irq;
  logic          tx_ovf;
  logic          rx_unf;
  logic          clr_flags;
  logic [7:0]    uart_txdata;
  logic          uart_write_tx;
  logic          uart_tx_empty;
  logic [7:0]    uart_rxdata;
  logic [7:0]    uart_status;
  logic          uart_rx_valid;
  logic          uart_read_rx;
  modport slave (
    input  tx_push, tx_wdata, tx_flush, rx_pop, rx_flush, clr_flags,
           uart_tx_empty, uart_rxdata, uart_status, uart_rx_valid,
    output tx_full, tx_count, rx_rdata, rx_rerr, rx_empty, rx_count, rx_irq,
           tx_ovf, rx_unf, uart_txdata, uart_write_tx, uart_read_rx
  );
  modport master (
    output tx_push, tx_wdata, tx_flush, rx_pop, rx_flush, clr_flags,
           uart_tx_empty, uart_rxdata, uart_status, uart_rx_valid,
    input  tx_full, tx_count, rx_rdata, rx_rerr, rx_empty, rx_count, rx_irq,
           tx_ovf, rx_unf, uart_txdata, uart_write_tx, uart_read_rx
  );
endinterface

// File: rtl/uart_host_fifo.sv
// uart_host_fifo: TX/RX FIFOs between the CPU register file and the UART core
module uart_host_fifo #(
  parameter int AW        = 4,
  parameter int RX_THRESH = 8
) (
  input logic              clk,
  input logic              rst_n,
  uart_host_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR  = (AW+1)'(RX_THRESH);
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]    txdata_q, txdata_d;
  logic          wtx_q, tx_ovf_q, tx_ovf_d, tx_wr, tx_issue;
  logic [12:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  logic          rrx_q, rx_unf_q, rx_unf_d, rx_rd, rx_drain;
  logic          unused_status;
  assign unused_status = ^{bus.uart_status[7], bus.uart_status[1:0]};
  // TX next state: host push and core issue, flush overriding both
  always_comb begin
    tx_wr    = bus.tx_push && tx_cnt_q != FULL && !bus.tx_flush;
    tx_issue = tx_cnt_q != '0 && bus.uart_tx_empty && !wtx_q && !bus.tx_flush;
    tx_wp_d  = bus.tx_flush ? '0 : tx_wp_q + AW'(tx_wr);
    tx_rp_d  = bus.tx_flush ? '0 : tx_rp_q + AW'(tx_issue);
    tx_cnt_d = bus.tx_flush ? '0 : tx_cnt_q + (AW+1)'(tx_wr) - (AW+1)'(tx_issue);
    txdata_d = tx_issue ? tx_mem_q[tx_rp_q] : txdata_q;
    tx_ovf_d = (bus.tx_push && tx_cnt_q == FULL) || (tx_ovf_q && !bus.clr_flags);
  end
  // RX next state: core drain and host pop, flush overriding both
  always_comb begin
    rx_drain = bus.uart_rx_valid && !rrx_q && rx_cnt_q != FULL && !bus.rx_flush;
    rx_rd    = bus.rx_pop && rx_cnt_q != '0 && !bus.rx_flush;
    rx_wp_d  = bus.rx_flush ? '0 : rx_wp_q + AW'(rx_drain);
    rx_rp_d  = bus.rx_flush ? '0 : rx_rp_q + AW'(rx_rd);
    rx_cnt_d = bus.rx_flush ? '0 : rx_cnt_q + (AW+1)'(rx_drain) - (AW+1)'(rx_rd);
    rx_unf_d = (bus.rx_pop && rx_cnt_q == '0) || (rx_unf_q && !bus.clr_flags);
  end
  // FIFO storage needs no reset: contents are invisible while count is 0
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem_q[tx_wp_q] <= bus.tx_wdata;
    if (rx_drain) rx_mem_q[rx_wp_q] <= {bus.uart_status[6:2], bus.uart_rxdata};
  end
  // Pointers, counts, core strobes and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      txdata_q <= '0;
      wtx_q    <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rrx_q    <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      txdata_q <= txdata_d;
      wtx_q    <= tx_issue;
      tx_ovf_q <= tx_ovf_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      rrx_q    <= rx_drain;
      rx_unf_q <= rx_unf_d;
    end
  end
  assign bus.tx_full       = tx_cnt_q == FULL;
  assign bus.tx_count      = tx_cnt_q;
  assign bus.rx_empty      = rx_cnt_q == '0;
  assign bus.rx_count      = rx_cnt_q;
  assign bus.rx_rdata      = rx_cnt_q == '0 ? 8'h00 : rx_mem_q[rx_rp_q][7:0];
  assign bus.rx_rerr       = rx_cnt_q == '0 ? 5'h00 : rx_mem_q[rx_rp_q][12:8];
  assign bus.rx_irq        = rx_cnt_q >= THR;
  assign bus.tx_ovf        = tx_ovf_q;
  assign bus.rx_unf        = rx_unf_q;
  assign bus.uart_txdata   = txdata_q;
  assign bus.uart_write_tx = wtx_q;
  assign bus.uart_read_rx  = rrx_q;
endmodule

// File: tb/tb_uart_host_fifo.sv
// tb_uart_host_fifo: directed scenarios plus random traffic against a queue model
module tb_uart_host_fifo;
  localparam int AW = 4, DEPTH = 16, THR = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_host_fifo_if #(.AW(AW)) bus();
  uart_host_fifo #(.AW(AW), .RX_THRESH(THR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  logic [7:0]  tx_q [$];
  logic [12:0] rx_q [$];
  logic [7:0]  m_txd;
  logic        m_wtx, m_rrx, m_ovf, m_unf;
  logic [7:0]  seen [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic compare_all();
    chk("tx_full", 32'(bus.tx_full), 32'(tx_q.size() == DEPTH));
    chk("tx_count", 32'(bus.tx_count), tx_q.size());
    chk("rx_empty", 32'(bus.rx_empty), 32'(rx_q.size() == 0));
    chk("rx_count", 32'(bus.rx_count), rx_q.size());
    chk("rx_rdata", 32'(bus.rx_rdata), rx_q.size() ? 32'(rx_q[0][7:0]) : 0);
    chk("rx_rerr", 32'(bus.rx_rerr), rx_q.size() ? 32'(rx_q[0][12:8]) : 0);
    chk("rx_irq", 32'(bus.rx_irq), 32'(rx_q.size() >= THR));
    chk("tx_ovf", 32'(bus.tx_ovf), 32'(m_ovf));
    chk("rx_unf", 32'(bus.rx_unf), 32'(m_unf));
    chk("uart_txdata", 32'(bus.uart_txdata), 32'(m_txd));
    chk("uart_write_tx", 32'(bus.uart_write_tx), 32'(m_wtx));
    chk("uart_read_rx", 32'(bus.uart_read_rx), 32'(m_rrx));
  endtask
  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    m_txd = 8'h00;
    m_wtx = 1'b0;
    m_rrx = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  task automatic model_step();
    int  ts = tx_q.size(), rs = rx_q.size();
    bit  issue = ts > 0 && bus.uart_tx_empty && !m_wtx && !bus.tx_flush;
    bit  drain = bus.uart_rx_valid && !m_rrx && rs < DEPTH && !bus.rx_flush;
    m_ovf = (bus.tx_push && ts == DEPTH) || (m_ovf && !bus.clr_flags);
    m_unf = (bus.rx_pop && rs == 0) || (m_unf && !bus.clr_flags);
    if (bus.tx_flush) tx_q.delete();
    else begin
      if (issue) m_txd = tx_q.pop_front();
      if (bus.tx_push && ts < DEPTH) tx_q.push_back(bus.tx_wdata);
    end
    if (bus.rx_flush) rx_q.delete();
    else begin
      if (bus.rx_pop && rs > 0) void'(rx_q.pop_front());
      if (drain) rx_q.push_back({bus.uart_status[6:2], bus.uart_rxdata});
    end
    m_wtx = issue;
    m_rrx = drain;
  endtask
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle();
    bus.tx_push = 0; bus.tx_wdata = 0; bus.tx_flush = 0; bus.rx_pop = 0;
    bus.rx_flush = 0; bus.clr_flags = 0; bus.uart_tx_empty = 0;
    bus.uart_rxdata = 0; bus.uart_status = 0; bus.uart_rx_valid = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    model_clear();
    compare_all();
    rst_n = 1'b1;
  endtask
  initial begin
    idle();
    do_reset();
    bus.uart_tx_empty = 1;
    bus.tx_push = 1; bus.tx_wdata = 8'h55; tick();
    bus.tx_wdata = 8'hA3; tick();
    bus.tx_push = 0;
    if (bus.uart_write_tx) seen.push_back(bus.uart_txdata);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.uart_write_tx) seen.push_back(bus.uart_txdata);
    end
    chk("t1_pulses", seen.size(), 2);
    chk("t1_first", seen.size() > 0 ? 32'(seen[0]) : 32'hFFFF, 32'h55);
    chk("t1_second", seen.size() > 1 ? 32'(seen[1]) : 32'hFFFF, 32'hA3);
    chk("t1_count", 32'(bus.tx_count), 0);
    idle();
    bus.uart_rx_valid = 1; bus.uart_rxdata = 8'h3C; bus.uart_status = 8'h0C;
    tick();
    chk("t2_read", 32'(bus.uart_read_rx), 1);
    chk("t2_rdata", 32'(bus.rx_rdata), 32'h3C);
    chk("t2_rerr", 32'(bus.rx_rerr), 32'b00011);
    chk("t2_count", 32'(bus.rx_count), 1);
    bus.uart_rx_valid = 0; tick();
    chk("t2_single", 32'(bus.uart_read_rx), 0);
    do_reset();
    bus.uart_rx_valid = 1;
    for (int i = 0; i < 60 && rx_q.size() < DEPTH; i++) begin
      bus.uart_rxdata = 8'($urandom); bus.uart_status = 8'($urandom);
      tick();
      if (rx_q.size() == THR) chk("t3_irq8", 32'(bus.rx_irq), 1);
    end
    chk("t3_full", 32'(bus.rx_count), 16);
    tick(); tick();
    chk("t3_hold", 32'(bus.uart_read_rx), 0);
    bus.rx_pop = 1; tick(); bus.rx_pop = 0;
    chk("t3_pop", 32'(bus.rx_count), 15);
    tick();
    chk("t3_redrain", 32'(bus.uart_read_rx), 1);
    chk("t3_refill", 32'(bus.rx_count), 16);
    do_reset();
    bus.tx_push = 1;
    for (int i = 0; i < 17; i++) begin
      bus.tx_wdata = 8'(i + 1);
      tick();
    end
    bus.tx_push = 0;
    chk("t4_full", 32'(bus.tx_full), 1);
    chk("t4_count", 32'(bus.tx_count), 16);
    chk("t4_ovf", 32'(bus.tx_ovf), 1);
    bus.clr_flags = 1; tick(); bus.clr_flags = 0;
    chk("t4_clr", 32'(bus.tx_ovf), 0);
    bus.tx_flush = 1; tick(); bus.tx_flush = 0;
    bus.tx_push = 1;
    for (int i = 0; i < 5; i++) tick();
    bus.uart_tx_empty = 1; tick();
    bus.tx_push = 0; bus.uart_tx_empty = 0;
    chk("t5_count", 32'(bus.tx_count), 5);
    chk("t5_strobe", 32'(bus.uart_write_tx), 1);
    bus.rx_flush = 1; tick(); bus.rx_flush = 0;
    bus.rx_pop = 1; tick();
    chk("t5_unf", 32'(bus.rx_unf), 1);
    chk("t5_rxcnt", 32'(bus.rx_count), 0);
    bus.clr_flags = 1; tick(); bus.rx_pop = 0;
    chk("t5_setwins", 32'(bus.rx_unf), 1);
    tick(); bus.clr_flags = 0;
    chk("t5_clr", 32'(bus.rx_unf), 0);
    do_reset();
    bus.tx_push = 1;
    for (int i = 0; i < 4; i++) begin
      bus.tx_wdata = 8'($urandom);
      tick();
    end
    bus.tx_push = 0; bus.uart_tx_empty = 1; tick();
    chk("t6_strobe", 32'(bus.uart_write_tx), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wtx", 32'(bus.uart_write_tx), 0);
    chk("t6_rst_cnt", 32'(bus.tx_count), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_nostrobe", 32'(bus.uart_write_tx), 0);
    bus.tx_push = 1; bus.tx_flush = 1; tick(); idle();
    chk("t6_flushpush", 32'(bus.tx_count), 0);
    for (int ph = 0; ph < 4; ph++) begin
      int p_push = (ph == 0) ? 85 : (ph == 1) ? 15 : 50;
      int p_txe  = (ph == 0) ? 15 : (ph == 1) ? 85 : 50;
      int p_val  = (ph == 2) ? 85 : (ph == 3) ? 15 : 50;
      int p_pop  = (ph == 2) ? 10 : (ph == 3) ? 85 : 50;
      for (int c = 0; c < 500; c++) begin
        bus.tx_push       = $urandom_range(99) < p_push;
        bus.tx_wdata      = 8'($urandom);
        bus.tx_flush      = $urandom_range(59) == 0;
        bus.uart_tx_empty = $urandom_range(99) < p_txe;
        bus.rx_pop        = $urandom_range(99) < p_pop;
        bus.rx_flush      = $urandom_range(59) == 0;
        bus.uart_rx_valid = $urandom_range(99) < p_val;
        bus.uart_rxdata   = 8'($urandom);
        bus.uart_status   = 8'($urandom);
        bus.clr_flags     = $urandom_range(24) == 0;
        tick();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
